// File: rtl/mem_responder_if.sv
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response bundle between the CPU memory port and
//               mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        err;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   modport master (
      output mem_read, mem_write, addr, wdata,
      input  rdata, ready, busy, err, rd_count, wr_count
   );

   modport slave (
      input  mem_read, mem_write, addr, wdata,
      output rdata, ready, busy, err, rd_count, wr_count
   );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding word memory with programmable wait states,
//               ready/err completion pulse and wrapping debug access counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   mem_responder_if.slave bus
);

   localparam int         c_DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_wait_cnt;
   logic [3:0]            w_wait_cnt_nxt;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [31:0]           r_wdata;
   logic                  r_write;
   logic                  r_bad;
   logic [31:0]           r_rdata;
   logic [15:0]           r_rd_count;
   logic [15:0]           r_wr_count;
   logic [31:0]           r_mem [0:c_DEPTH-1];

   logic                  w_start;
   logic                  w_enter_done;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [31:0]           w_wdata;
   logic                  w_write;
   logic                  w_bad;
   logic                  w_unused_addr;

   assign w_unused_addr = ^bus.addr[31:DEPTH_LOG2+2];
   assign w_start       = bus.mem_read | bus.mem_write;

   // In IDLE the live request is used so a zero-wait access completes on its sampling edge.
   always_comb begin
      w_idx   = r_idx;
      w_wdata = r_wdata;
      w_write = r_write;
      w_bad   = r_bad;
      if (r_state == S_IDLE) begin
         w_idx   = bus.addr[DEPTH_LOG2+1:2];
         w_wdata = bus.wdata;
         w_write = bus.mem_write;
         w_bad   = (bus.mem_read & bus.mem_write) | (bus.addr[1:0] != 2'b00);
      end
   end

   always_comb begin
      w_next         = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               if (WAIT_CYCLES == 0) begin
                  w_next = S_DONE;
               end else begin
                  w_next         = S_WAIT;
                  w_wait_cnt_nxt = c_WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (r_wait_cnt == 4'd0) begin
               w_next = S_DONE;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt - 4'd1;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= 4'd0;
         r_idx      <= '0;
         r_wdata    <= 32'd0;
         r_write    <= 1'b0;
         r_bad      <= 1'b0;
         r_rdata    <= 32'd0;
         r_rd_count <= 16'd0;
         r_wr_count <= 16'd0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_cnt_nxt;
         if ((r_state == S_IDLE) && w_start) begin
            r_idx   <= w_idx;
            r_wdata <= w_wdata;
            r_write <= w_write;
            r_bad   <= w_bad;
         end
         if (w_enter_done && !w_bad) begin
            if (w_write) begin
               r_wr_count <= r_wr_count + 16'd1;
            end else begin
               r_rdata    <= r_mem[w_idx];
               r_rd_count <= r_rd_count + 16'd1;
            end
         end
      end
   end

   // Storage has no reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (w_enter_done && w_write && !w_bad) begin
         r_mem[w_idx] <= w_wdata;
      end
   end

   assign bus.rdata    = r_rdata;
   assign bus.ready    = (r_state == S_DONE);
   assign bus.err      = (r_state == S_DONE) & r_bad;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.rd_count = r_rd_count;
   assign bus.wr_count = r_wr_count;

endmodule

`default_nettype wire
